// File: rtl/filter_svf_pkg.sv
// Shared definitions for the multi-voice Chamberlin state variable filter.
//   - svf_state_e : sequencing FSM states
//   - MODE_*      : response select encodings on the mode input
//   - Q_FRAC / F_FRAC : fractional bits of Q1 (2.16) and F (1.17)
//   - COEF_BITS   : width of the F and Q1 coefficients
package filter_svf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MUL_Q  = 3'd1,
        ST_MUL_FB = 3'd2,
        ST_MUL_FH = 3'd3,
        ST_OUT    = 3'd4
    } svf_state_e;

    localparam logic [1:0] MODE_LP    = 2'd0;
    localparam logic [1:0] MODE_BP    = 2'd1;
    localparam logic [1:0] MODE_HP    = 2'd2;
    localparam logic [1:0] MODE_NOTCH = 2'd3;

    localparam int Q_FRAC    = 16;
    localparam int F_FRAC    = 17;
    localparam int COEF_BITS = 18;

endpackage

// File: rtl/svf_mul_shift.sv
// Shared signed multiplier for the filter datapath: SW x COEF_BITS full
// precision product, arithmetic right shift by Q_FRAC or F_FRAC, result
// truncated to SW bits.
//   a_i       : signed SW-bit operand (state or hp)
//   b_i       : signed coefficient (F or Q1)
//   shift_f_i : 1 selects F_FRAC shift, 0 selects Q_FRAC shift
//   p_o       : shifted, truncated product
module svf_mul_shift
    import filter_svf_pkg::*;
#(
    parameter int SW = 15
) (
    input  logic signed [SW-1:0]        a_i,
    input  logic signed [COEF_BITS-1:0] b_i,
    input  logic                        shift_f_i,
    output logic signed [SW-1:0]        p_o
);

    localparam int PW = SW + COEF_BITS;

    logic signed [PW-1:0] a_ext_s;
    logic signed [PW-1:0] b_ext_s;
    logic signed [PW-1:0] prod_s;

    // Sign-extend both operands to the exact product width, multiply, shift.
    always_comb begin
        a_ext_s = {{COEF_BITS{a_i[SW-1]}}, a_i};
        b_ext_s = {{SW{b_i[COEF_BITS-1]}}, b_i};
        prod_s  = a_ext_s * b_ext_s;
        if (shift_f_i) begin
            p_o = SW'(prod_s >>> F_FRAC);
        end else begin
            p_o = SW'(prod_s >>> Q_FRAC);
        end
    end

endmodule

// File: rtl/filter_svf_multi.sv
// Time-multiplexed multi-voice Chamberlin state variable filter.
// One sample is processed at a time through IDLE -> MUL_Q -> MUL_FB ->
// MUL_FH -> OUT using a single shared multiplier; per-voice lp/bp state is
// kept in register arrays.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : input handshake; in_voice, in_sample, F, Q1, mode
//                           are captured on acceptance
//   clr                   : synchronous clear of all voice states, aborts work
//   out_valid/out_ready   : output handshake; out_voice, out_sample held in OUT
// Build option: FILTER_SVF_MULTI_STATE_SAT_EN saturates lp'/bp' to the
// internal SW range before write-back (otherwise they wrap).
module filter_svf_multi
    import filter_svf_pkg::*;
#(
    parameter int SAMPLE_BITS = 12,
    parameter int VOICES      = 4,
    parameter int VOICE_BITS  = (VOICES > 1) ? $clog2(VOICES) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [VOICE_BITS-1:0]  in_voice,
    input  logic [SAMPLE_BITS-1:0] in_sample,
    input  logic [COEF_BITS-1:0]   F,
    input  logic [COEF_BITS-1:0]   Q1,
    input  logic [1:0]             mode,
    input  logic                   clr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [VOICE_BITS-1:0]  out_voice,
    output logic [SAMPLE_BITS-1:0] out_sample
);

    localparam int SW = SAMPLE_BITS + 3;

    svf_state_e state_q, state_d;
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic [VOICE_BITS-1:0]  out_voice_q;
    logic [SAMPLE_BITS-1:0] out_sample_q;

    logic signed [SW-1:0]        in_q, lp_w_q, bp_w_q, t_q;
    logic signed [COEF_BITS-1:0] f_q, q1_q;
    logic [1:0]                  mode_q;
    logic [VOICE_BITS-1:0]       voice_q;
    logic                        voice_ok_q;
    logic signed [SW-1:0]        lp_mem_q [VOICES];
    logic signed [SW-1:0]        bp_mem_q [VOICES];

    logic signed [SW-1:0]        mul_a_s, mul_p_s;
    logic signed [COEF_BITS-1:0] mul_b_s;
    logic                        mul_shf_s;
    logic signed [SW:0]          lp_sum_s, bp_sum_s;
    logic signed [SW-1:0]        lp_new_s, bp_new_s, hp_s, notch_s, resp_s, in_ext_s;
    logic                        in_voice_ok_s;

`ifdef FILTER_SVF_MULTI_STATE_SAT_EN
    // Limit an SW+1 bit sum to the signed SW range.
    function automatic logic signed [SW-1:0] sat_sw(input logic signed [SW:0] v);
        logic signed [SW-1:0] r;
        if (v[SW] != v[SW-1]) begin
            if (v[SW]) begin
                r = {1'b1, {(SW-1){1'b0}}};
            end else begin
                r = {1'b0, {(SW-1){1'b1}}};
            end
        end else begin
            r = SW'(v);
        end
        return r;
    endfunction
`endif

    // Clamp an internal SW value to the output sample range.
    function automatic logic [SAMPLE_BITS-1:0] clamp_out(input logic signed [SW-1:0] v);
        logic signed [SW-1:0] max_v, min_v;
        logic [SAMPLE_BITS-1:0] r;
        max_v = {{(SW-SAMPLE_BITS+1){1'b0}}, {(SAMPLE_BITS-1){1'b1}}};
        min_v = {{(SW-SAMPLE_BITS+1){1'b1}}, {(SAMPLE_BITS-1){1'b0}}};
        if (v > max_v) begin
            r = SAMPLE_BITS'(max_v);
        end else if (v < min_v) begin
            r = SAMPLE_BITS'(min_v);
        end else begin
            r = SAMPLE_BITS'(v);
        end
        return r;
    endfunction

    svf_mul_shift #(.SW(SW)) u_mul (
        .a_i       (mul_a_s),
        .b_i       (mul_b_s),
        .shift_f_i (mul_shf_s),
        .p_o       (mul_p_s)
    );

    // Input decode: sign extension and voice range test (out-of-range voices use zero state).
    always_comb begin
        in_ext_s      = {{(SW-SAMPLE_BITS){in_sample[SAMPLE_BITS-1]}}, in_sample};
        in_voice_ok_s = ({{(32-VOICE_BITS){1'b0}}, in_voice} < 32'(VOICES));
    end

    // Multiplier operand selection per FSM step.
    always_comb begin
        mul_a_s   = bp_w_q;
        mul_b_s   = q1_q;
        mul_shf_s = 1'b0;
        case (state_q)
            ST_MUL_Q:  begin mul_a_s = bp_w_q; mul_b_s = q1_q; mul_shf_s = 1'b0; end
            ST_MUL_FB: begin mul_a_s = bp_w_q; mul_b_s = f_q;  mul_shf_s = 1'b1; end
            ST_MUL_FH: begin mul_a_s = t_q;    mul_b_s = f_q;  mul_shf_s = 1'b1; end
            default:   begin mul_a_s = bp_w_q; mul_b_s = q1_q; mul_shf_s = 1'b0; end
        endcase
    end

    // Filter arithmetic. t_q holds q during MUL_FB and hp during MUL_FH;
    // lp_w_q already holds lp' by MUL_FH.
    always_comb begin
        lp_sum_s = {lp_w_q[SW-1], lp_w_q} + {mul_p_s[SW-1], mul_p_s};
        bp_sum_s = {bp_w_q[SW-1], bp_w_q} + {mul_p_s[SW-1], mul_p_s};
`ifdef FILTER_SVF_MULTI_STATE_SAT_EN
        lp_new_s = sat_sw(lp_sum_s);
        bp_new_s = sat_sw(bp_sum_s);
`else
        lp_new_s = SW'(lp_sum_s);
        bp_new_s = SW'(bp_sum_s);
`endif
        hp_s    = in_q - t_q - lp_new_s;
        notch_s = t_q + lp_w_q;
        case (mode_q)
            MODE_LP:    resp_s = lp_w_q;
            MODE_BP:    resp_s = bp_new_s;
            MODE_HP:    resp_s = t_q;
            MODE_NOTCH: resp_s = notch_s;
            default:    resp_s = lp_w_q;
        endcase
    end

    // Next-state logic; clr overrides everything and returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_MUL_Q;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL_Q:  state_d = ST_MUL_FB;
            ST_MUL_FB: state_d = ST_MUL_FH;
            ST_MUL_FH: state_d = ST_OUT;
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (clr) begin
            state_d = ST_IDLE;
        end else begin
            state_d = state_d;
        end
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_OUT);
    end

    // FSM state and handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Working registers and output data; frozen while clr is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q         <= {SW{1'b0}};
            lp_w_q       <= {SW{1'b0}};
            bp_w_q       <= {SW{1'b0}};
            t_q          <= {SW{1'b0}};
            f_q          <= {COEF_BITS{1'b0}};
            q1_q         <= {COEF_BITS{1'b0}};
            mode_q       <= MODE_LP;
            voice_q      <= {VOICE_BITS{1'b0}};
            voice_ok_q   <= 1'b0;
            out_voice_q  <= {VOICE_BITS{1'b0}};
            out_sample_q <= {SAMPLE_BITS{1'b0}};
        end else if (!clr) begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        in_q       <= in_ext_s;
                        f_q        <= F;
                        q1_q       <= Q1;
                        mode_q     <= mode;
                        voice_q    <= in_voice;
                        voice_ok_q <= in_voice_ok_s;
                        lp_w_q     <= in_voice_ok_s ? lp_mem_q[in_voice] : {SW{1'b0}};
                        bp_w_q     <= in_voice_ok_s ? bp_mem_q[in_voice] : {SW{1'b0}};
                    end
                end
                ST_MUL_Q:  t_q <= mul_p_s;
                ST_MUL_FB: begin
                    lp_w_q <= lp_new_s;
                    t_q    <= hp_s;
                end
                ST_MUL_FH: begin
                    bp_w_q       <= bp_new_s;
                    out_voice_q  <= voice_q;
                    out_sample_q <= clamp_out(resp_s);
                end
                default: begin end
            endcase
        end
    end

    // Per-voice state storage: cleared by clr, written back at the end of MUL_FH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < VOICES; i++) begin
                lp_mem_q[i] <= {SW{1'b0}};
                bp_mem_q[i] <= {SW{1'b0}};
            end
        end else if (clr) begin
            for (int i = 0; i < VOICES; i++) begin
                lp_mem_q[i] <= {SW{1'b0}};
                bp_mem_q[i] <= {SW{1'b0}};
            end
        end else if (state_q == ST_MUL_FH && voice_ok_q) begin
            lp_mem_q[voice_q] <= lp_w_q;
            bp_mem_q[voice_q] <= bp_new_s;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_voice  = out_voice_q;
    assign out_sample = out_sample_q;

endmodule
